// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and FSM state encoding for the instruction
//                fetch front end of the 8-bit accumulator processor.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Default widths of the fetch datapath
  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 8;

  // Instruction byte layout: {opcode[7:5], immediate[4:0]}
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int IMM_W   = 5;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small prefetch FIFO holding {pc, instruction} entries.
//                Synchronous flush, occupancy count, zero head when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  // Pointer advance with explicit wrap so non-power-of-two ranges stay safe
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  // Pop on empty is ignored; push into a full FIFO only with a simultaneous pop
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Pointer and occupancy bookkeeping; flush discards all entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch front end. Owns the PC, issues req/ack
//                memory reads with credit-based flow control into a prefetch
//                FIFO, and handles branch redirects including in-flight drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              brnch,
  input  logic [ADDR_W-1:0] brnch_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [2:0]        opcode,
  output logic [4:0]        immediate,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic              r_req;

  logic [CNT_W-1:0]  w_count;
  logic [ENT_W-1:0]  w_head;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic [CNT_W:0]    w_count_after;
  logic              w_has_room;
  logic              w_room_after;

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & instr_ready;
  // Acked data is only kept when no redirect arrives in the same cycle
  assign w_push  = (r_state == WAIT) & mem_ack & ~brnch;

  // Occupancy after this cycle's push/pop; decides whether to keep requesting
  assign w_count_after = {1'b0, w_count} + {{CNT_W{1'b0}}, w_push}
                       - {{CNT_W{1'b0}}, w_pop};
  assign w_room_after  = (w_count_after < (CNT_W+1)'(DEPTH));
  assign w_has_room    = ({1'b0, w_count} < (CNT_W+1)'(DEPTH));

  // Fetch FSM: PC, request address and request strobe are all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (brnch) begin
            r_pc    <= brnch_target;
            r_addr  <= brnch_target;
            r_req   <= 1'b1;
            r_state <= WAIT;
          end else if (w_has_room) begin
            r_addr  <= r_pc;
            r_req   <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (brnch) begin
            r_pc <= brnch_target;
            if (mem_ack) begin
              // Old request completed this cycle: redirect immediately
              r_addr <= brnch_target;
            end else begin
              // Old request still pending: hold it and discard its data later
              r_state <= DROP;
            end
          end else if (mem_ack) begin
            r_pc <= r_pc + 1'b1;
            if (w_room_after) begin
              r_addr <= r_pc + 1'b1;
            end else begin
              r_req   <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        DROP: begin
          if (mem_ack) begin
            // Stale data retired; request the redirect target (FIFO is empty)
            r_pc    <= brnch ? brnch_target : r_pc;
            r_addr  <= brnch ? brnch_target : r_pc;
            r_state <= WAIT;
          end else if (brnch) begin
            r_pc <= brnch_target;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (brnch),
    .i_push  (w_push),
    .i_data  ({r_addr, mem_rdata}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign mem_req     = r_req;
  assign mem_addr    = r_addr;
  assign instr_valid = w_valid;
  assign instr       = w_head[DATA_W-1:0];
  assign instr_pc    = w_head[ENT_W-1:DATA_W];
  assign opcode      = instr[OPC_MSB:OPC_LSB];
  assign immediate   = instr[IMM_W-1:0];

endmodule : instr_fetch
`default_nettype wire
